qpmm_final_reduce: RTL and testbench



---
 rtl/qpmm_final_reduce.sv | 116 +++++++++++
 tb/tb_qpmm_final_reduce.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/qpmm_final_reduce.sv
// qpmm_final_reduce: final reduction stage of the QPMM Montgomery multiplier.
// Takes a redundant LIMB_W*N_LIMBS-bit product (< (PASSES+1)*MOD) and returns
// the canonical residue in [0,MOD). Works limb-serially, one limb per cycle,
// with a conditional subtraction of MOD on each pass.
// Optional feature macro: QPMM_FINAL_REDUCE_EARLY_EXIT_EN
//   undefined (default): always PASSES passes, constant-time.
//   defined: stop after the first pass whose subtraction borrows (not constant-time).
module qpmm_final_reduce #(
    parameter int LIMB_W  = 16,
    parameter int N_LIMBS = 17,
    parameter logic [LIMB_W*N_LIMBS-1:0] MOD =
        (LIMB_W*N_LIMBS)'(256'h2523648240000001ba344d80000000086121000000000013a700000000000013),
    parameter int PASSES  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LIMB_W*N_LIMBS-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LIMB_W*N_LIMBS-1:0]   out_data,
    output logic                        busy
);

    localparam int W  = LIMB_W * N_LIMBS;
    localparam int IW = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(N_LIMBS - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [W-1:0]      acc;
    logic [W-1:0]      diff;
    logic [IW-1:0]     idx;
    logic [PW-1:0]     pass;
    logic              borrow;

    logic [LIMB_W-1:0] acc_limb;
    logic [LIMB_W-1:0] mod_limb;
    logic [LIMB_W:0]   sub_res;
    logic [W-1:0]      diff_next;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;

    // One limb of acc - MOD - borrow; diff_next is diff with the current limb updated.
    always_comb begin
        acc_limb  = acc[int'(idx)*LIMB_W +: LIMB_W];
        mod_limb  = MOD[int'(idx)*LIMB_W +: LIMB_W];
        sub_res   = {1'b0, acc_limb} - {1'b0, mod_limb} - (LIMB_W+1)'(borrow);
        diff_next = diff;
        diff_next[int'(idx)*LIMB_W +: LIMB_W] = sub_res[LIMB_W-1:0];
    end

    // Control FSM and datapath registers; acc is replaced by diff only at pass end without borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            diff   <= '0;
            idx    <= '0;
            pass   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= in_data;
                        idx    <= '0;
                        pass   <= '0;
                        borrow <= 1'b0;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    diff <= diff_next;
                    if (idx == IDX_LAST) begin
                        if (!sub_res[LIMB_W]) begin
                            acc <= diff_next;
                        end
                        idx    <= '0;
                        borrow <= 1'b0;
                        pass   <= pass + PW'(1);
`ifdef QPMM_FINAL_REDUCE_EARLY_EXIT_EN
                        if ((pass == PASS_LAST) || sub_res[LIMB_W]) begin
                            state <= DONE;
                        end
`else
                        if (pass == PASS_LAST) begin
                            state <= DONE;
                        end
`endif
                    end else begin
                        idx    <= idx + IW'(1);
                        borrow <= sub_res[LIMB_W];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qpmm_final_reduce.sv
// Testbench for qpmm_final_reduce: directed corner cases plus random operands,
// checked against a plain-arithmetic model of repeated conditional subtraction.
// Follows the QPMM_FINAL_REDUCE_EARLY_EXIT_EN macro for expected latency.
module tb_qpmm_final_reduce;

    localparam int LIMB_W  = 16;
    localparam int N_LIMBS = 17;
    localparam int PASSES  = 3;
    localparam int W       = LIMB_W * N_LIMBS;
    localparam logic [W-1:0] MOD =
        {16'h0, 256'h2523648240000001ba344d80000000086121000000000013a700000000000013};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qpmm_final_reduce #(
        .LIMB_W (LIMB_W),
        .N_LIMBS(N_LIMBS),
        .MOD    (MOD),
        .PASSES (PASSES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: subtract MOD while the value is still >= MOD, at most PASSES times.
    function automatic void ref_reduce(input logic [W-1:0] x, output logic [W-1:0] r, output int lat);
        r   = x;
        lat = 0;
        for (int p = 0; p < PASSES; p++) begin
            lat += N_LIMBS;
            if (r >= MOD) r = r - MOD;
`ifdef QPMM_FINAL_REDUCE_EARLY_EXIT_EN
            else break;
`endif
        end
    endfunction

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] x, input int hold, input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] held;
        int           lat;
        int           cycles;
        ref_reduce(x, exp, lat);
        check_eq({tag, "_ready_idle"}, W'(in_ready), W'(1));
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd_wide();
        check_eq({tag, "_busy"}, W'(busy), W'(1));
        check_eq({tag, "_ready_sub"}, W'(in_ready), W'(0));
        cycles = 0;
        while (!out_valid && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq({tag, "_latency"}, W'(cycles), W'(lat));
        check_eq({tag, "_data"}, out_data, exp);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, W'(out_valid), W'(1));
            check_eq({tag, "_hold_data"}, out_data, held);
            check_eq({tag, "_hold_ready"}, W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_drain_valid"}, W'(out_valid), W'(0));
        check_eq({tag, "_drain_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        check_eq("rst_valid", W'(out_valid), W'(0));
        check_eq("rst_data", out_data, '0);
        check_eq("rst_busy", W'(busy), W'(0));
        check_eq("rst_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op('0, 0, "zero");
        run_op(MOD - W'(1), 0, "mod_m1");
        run_op(MOD, 0, "mod");
        run_op(MOD * 3 + W'(5), 0, "mod3_p5");
        run_op(MOD * 4, 10, "mod4_illegal");
        run_op(W'(5), 0, "five");
        run_op(MOD + W'(1), 0, "mod_p1");
        run_op(MOD * 2, 2, "mod2");

        // Abort mid-operation with an asynchronous reset.
        in_data  = MOD * 2 + W'(7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", W'(out_valid), W'(0));
        check_eq("abort_ready", W'(in_ready), W'(1));
        check_eq("abort_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(W'(9), 0, "after_abort");

        for (int i = 0; i < 12; i++) begin
            run_op(rnd_wide() % (MOD * 4), i % 3, "rand_legal");
        end
        for (int i = 0; i < 3; i++) begin
            run_op(MOD * 4 + (rnd_wide() % MOD), 0, "rand_illegal");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
